// File: rtl/forward_unit.sv
// forward_unit
//   Data-forwarding unit for a 5-stage pipeline. Tracks destination-register
//   tags of the instructions in EX/MEM and MEM/WB (shadow of the datapath
//   latches) and produces the EX-stage ALU operand selects plus the load-use
//   stall request.
//
//   Optional feature macro: FWD_PERF_COUNTERS_EN
//     defined     -> fwd_count / stall_count are saturating event counters
//     not defined -> both ports tied to 0, no counter flops
//
// Ports
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   en                       pipeline advance, same enable as the datapath latches
//   bubble                   with en: EX instruction not promoted, MEM tag invalid
//   ex_valid/ex_regwrite/
//   ex_memtoreg/ex_wsel      EX instruction attributes and destination
//   ex_rs, ex_rt             EX sources for operand A / B
//   id_rs, id_rt             decode sources for load-use detection
//   forwarda, forwardb       00 = register file, 01 = EX/MEM, 10 = MEM/WB
//   load_use_stall           stall IF/ID and insert a bubble
//   fwd_count, stall_count   performance counters (feature-gated)

module forward_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             bubble,
  input  logic             ex_valid,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic [1:0]       forwarda,
  output logic [1:0]       forwardb,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] fwd_count,
  output logic [CNT_W-1:0] stall_count
);

  logic             mv, mrw, wv, wrw;
  logic [REG_W-1:0] mwsel, wwsel;

  // Shadow tag pipeline; the MEM field values are irrelevant when mv=0,
  // so they are loaded unconditionally and only mv honours bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mv    <= 1'b0;
      mrw   <= 1'b0;
      mwsel <= '0;
      wv    <= 1'b0;
      wrw   <= 1'b0;
      wwsel <= '0;
    end else if (en) begin
      wv    <= mv;
      wrw   <= mrw;
      wwsel <= mwsel;
      mv    <= ex_valid & ~bubble;
      mrw   <= ex_regwrite;
      mwsel <= ex_wsel;
    end
  end

  logic mem_prod, wb_prod;
  assign mem_prod = mv & mrw & (mwsel != '0);
  assign wb_prod  = wv & wrw & (wwsel != '0);

  // Youngest producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    forwarda = 2'b00;
    if (mem_prod && (mwsel == ex_rs))     forwarda = 2'b01;
    else if (wb_prod && (wwsel == ex_rs)) forwarda = 2'b10;
  end

  always_comb begin
    forwardb = 2'b00;
    if (mem_prod && (mwsel == ex_rt))     forwardb = 2'b01;
    else if (wb_prod && (wwsel == ex_rt)) forwardb = 2'b10;
  end

  // Masked during reset so the request reads 0 regardless of EX inputs.
  assign load_use_stall = ~RST & ex_valid & ex_regwrite & ex_memtoreg
                        & (ex_wsel != '0)
                        & ((ex_wsel == id_rs) | (ex_wsel == id_rt));

`ifdef FWD_PERF_COUNTERS_EN
  logic any_fwd;
  assign any_fwd = (forwarda != 2'b00) | (forwardb != 2'b00);

  always_ff @(posedge CLK) begin
    if (RST) begin
      fwd_count   <= '0;
      stall_count <= '0;
    end else begin
      if (en && any_fwd && (fwd_count != '1))
        fwd_count <= fwd_count + 1'b1;
      if (load_use_stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end
`else
  assign fwd_count   = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_forward_unit.sv
module tb_forward_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  logic             CLK = 1'b0;
  logic             RST;
  logic             en, bubble, ex_valid, ex_regwrite, ex_memtoreg;
  logic [REG_W-1:0] ex_wsel, ex_rs, ex_rt, id_rs, id_rt;
  logic [1:0]       forwarda, forwardb;
  logic             load_use_stall;
  logic [CNT_W-1:0] fwd_count, stall_count;

  forward_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .en(en), .bubble(bubble),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_wsel(ex_wsel), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt),
    .forwarda(forwarda), .forwardb(forwardb), .load_use_stall(load_use_stall),
    .fwd_count(fwd_count), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the register each older in-flight instruction will
  // write, -1 when it writes nothing forwardable.
  int h_mem = -1;
  int h_wb  = -1;
  longint unsigned m_fwd = 0, m_stall = 0;
  localparam longint unsigned CMAX = (64'd1 << CNT_W) - 1;
  bit armed = 0;

  function automatic int src_sel(input int src);
    if (h_mem == src) return 1;
    if (h_wb == src) return 2;
    return 0;
  endfunction

  // One cycle: drive at negedge, check combinational outputs, clock, update model.
  task automatic step(input bit r, input bit v, input bit rw, input bit mtr,
                      input int wsel, input int rs, input int rt,
                      input int irs, input int irt, input bit e, input bit b,
                      output int fa, output int fb, output bit st);
    int ea, eb;
    bit es;
    @(negedge CLK);
    RST = r; ex_valid = v; ex_regwrite = rw; ex_memtoreg = mtr;
    ex_wsel = wsel[REG_W-1:0]; ex_rs = rs[REG_W-1:0]; ex_rt = rt[REG_W-1:0];
    id_rs = irs[REG_W-1:0]; id_rt = irt[REG_W-1:0]; en = e; bubble = b;
    #1;
    ea = src_sel(rs);
    eb = src_sel(rt);
    es = !r && v && rw && mtr && wsel != 0 && (wsel == irs || wsel == irt);
    fa = int'(forwarda); fb = int'(forwardb); st = load_use_stall;
    if (armed) begin
      chk("forwarda", forwarda, ea);
      chk("forwardb", forwardb, eb);
      chk("load_use_stall", load_use_stall, es);
`ifdef FWD_PERF_COUNTERS_EN
      chk("fwd_count", fwd_count, m_fwd);
      chk("stall_count", stall_count, m_stall);
`else
      chk("fwd_count", fwd_count, 0);
      chk("stall_count", stall_count, 0);
`endif
    end
    @(posedge CLK);
    if (r) begin
      h_mem = -1; h_wb = -1; m_fwd = 0; m_stall = 0;
    end else begin
      if (e && (ea != 0 || eb != 0) && m_fwd != CMAX) m_fwd++;
      if (es && m_stall != CMAX) m_stall++;
      if (e) begin
        h_wb  = h_mem;
        h_mem = (!b && v && rw && wsel != 0) ? wsel : -1;
      end
    end
    armed = 1;
  endtask

  task automatic rand_step(input bit r, output int fa, output int fb, output bit st);
    step(r, $urandom_range(0, 9) < 8, $urandom_range(0, 1), $urandom_range(0, 1),
         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
         $urandom_range(0, 3), $urandom_range(0, 3),
         $urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, fa, fb, st);
  endtask

  initial begin
    int fa, fb;
    bit st;

    // Reset with random inputs
    rand_step(1, fa, fb, st);
    rand_step(1, fa, fb, st);
    rand_step(1, fa, fb, st);
    chk("reset_fwda", fa, 0);
    chk("reset_stall", st, 0);

    // EX->EX forward: add $3, then consumer reads $3 on both operands
    step(0, 1, 1, 0, 3, 0, 0, 0, 0, 1, 0, fa, fb, st);
    step(0, 1, 1, 0, 9, 3, 3, 0, 0, 1, 0, fa, fb, st);
    chk("exex_fwda", fa, 1);
    chk("exex_fwdb", fb, 1);

    // Priority: two writers of $5, reader gets EX/MEM; bubble the newest -> MEM/WB
    step(0, 1, 1, 0, 5, 0, 0, 0, 0, 1, 0, fa, fb, st);
    step(0, 1, 1, 0, 5, 0, 0, 0, 0, 1, 0, fa, fb, st);
    step(0, 1, 0, 0, 0, 5, 0, 0, 0, 1, 1, fa, fb, st);
    chk("prio_mem", fa, 1);
    step(0, 1, 0, 0, 0, 5, 0, 0, 0, 1, 0, fa, fb, st);
    chk("prio_wb", fa, 2);

    // $0 guard
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, fa, fb, st);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, fa, fb, st);
    chk("zero_guard", fa, 0);

    // Load-use: lw $4 with id_rt=4, bubble edge, consumer gets MEM/WB
    step(0, 1, 1, 1, 4, 0, 0, 1, 4, 1, 0, fa, fb, st);
    chk("lu_stall", st, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, fa, fb, st);
    step(0, 1, 0, 0, 0, 0, 4, 0, 0, 1, 0, fa, fb, st);
    chk("lu_fwdb", fb, 2);

    // Hold: forwarda=01 stays put across three en=0 cycles
    step(0, 1, 1, 0, 7, 0, 0, 0, 0, 1, 0, fa, fb, st);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 2, 7, 0, 0, 0, 0, $urandom_range(0, 1), fa, fb, st);
      chk("hold_fwda", fa, 1);
    end
    step(0, 1, 0, 0, 0, 7, 0, 0, 0, 1, 0, fa, fb, st);
    chk("after_hold", fa, 1);

    // Randomized traffic, with occasional mid-run resets
    for (int i = 0; i < 3000; i++)
      rand_step($urandom_range(0, 199) == 0, fa, fb, st);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
